// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: runs mult/multu/div/divu over a
// fixed number of busy cycles and owns the architectural HI/LO pair.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   Start, MDUOp      operation request and opcode (0..8)
//   SrcA, SrcB        forwarded rs/rt operands
//   Req               flush: the EX instruction must not take effect
//   Busy              operation in progress (to hazard unit)
//   HI, LO            architectural HI/LO registers
//   MDUOut            mfhi/mflo read data, 0 for other opcodes
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] N_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] N_DIV  = 4'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] sh_hi_q, sh_hi_d;
    logic [31:0] sh_lo_q, sh_lo_d;
    logic        dz_q, dz_d;

    logic        busy;
    logic        start_ok;
    logic        mt_ok;
    logic        b_zero;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] uq, ur;
    logic [31:0] sq, sr;
    logic [31:0] dq, dr;
    logic [63:0] prod_s, prod_u;

    assign busy = (state_q == S_RUN);

    assign start_ok = Start && !Req && !busy &&
                      (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
    assign mt_ok = !Req && !busy;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    assign prod_u = {32'd0, SrcA} * {32'd0, SrcB};

    assign b_zero = (SrcB == 32'd0);
    assign a_neg  = SrcA[31];
    assign b_neg  = SrcB[31];
    assign a_mag  = a_neg ? (32'd0 - SrcA) : SrcA;
    assign b_mag  = b_neg ? (32'd0 - SrcB) : SrcB;

    // Signed divide done on magnitudes; 0x80000000 / -1 wraps to
    // 0x80000000 with zero remainder without a special case.
    always_comb begin
        uq = 32'd0;
        ur = 32'd0;
        dq = 32'd0;
        dr = 32'd0;
        if (!b_zero) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
            dq = SrcA / SrcB;
            dr = SrcA % SrcB;
        end
    end

    assign sq = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign sr = a_neg ? (32'd0 - ur) : ur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        dz_d    = dz_q;
        if (busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = S_IDLE;
                if (!dz_q) begin
                    hi_d = sh_hi_q;
                    lo_d = sh_lo_q;
                end
            end
        end else if (start_ok) begin
            state_d = S_RUN;
            dz_d    = 1'b0;
            unique case (MDUOp)
                OP_MULT: begin
                    {sh_hi_d, sh_lo_d} = prod_s;
                    cnt_d = N_MULT;
                end
                OP_MULTU: begin
                    {sh_hi_d, sh_lo_d} = prod_u;
                    cnt_d = N_MULT;
                end
                OP_DIV: begin
                    sh_hi_d = sr;
                    sh_lo_d = sq;
                    dz_d    = b_zero;
                    cnt_d   = N_DIV;
                end
                default: begin
                    sh_hi_d = dr;
                    sh_lo_d = dq;
                    dz_d    = b_zero;
                    cnt_d   = N_DIV;
                end
            endcase
        end else if (mt_ok) begin
            if (MDUOp == OP_MTHI) hi_d = SrcA;
            if (MDUOp == OP_MTLO) lo_d = SrcA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sh_hi_q <= 32'd0;
            sh_lo_q <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        MDUOut = 32'd0;
        if (MDUOp == OP_MFHI) MDUOut = hi_q;
        if (MDUOp == OP_MFLO) MDUOut = lo_q;
    end

    assign Busy = busy;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Steps through the multiply/divide, HI/LO access, flush and reset cases.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int n_chk;
    int n_fail;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .MDUOp  (MDUOp),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Req    (Req),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, check N busy cycles with HI/LO frozen, then result.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] ehi,
                          input logic [31:0] elo);
        MDUOp = op;
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        MDUOp = 4'd0;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, Busy}, 32'd1);
            chk({tag, " hi hold"}, HI, cur_hi);
            chk({tag, " lo hold"}, LO, cur_lo);
            tick();
        end
        chk({tag, " busy fall"}, {31'd0, Busy}, 32'd0);
        chk({tag, " hi"}, HI, ehi);
        chk({tag, " lo"}, LO, elo);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        reset  = 1'b0;
        Start  = 1'b0;
        MDUOp  = 4'd0;
        SrcA   = 32'd0;
        SrcB   = 32'd0;
        Req    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst busy", {31'd0, Busy}, 32'd0);
        chk("rst hi", HI, 32'd0);
        chk("rst lo", LO, 32'd0);
        tick();
        chk("rst held busy", {31'd0, Busy}, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 5,
               32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
               32'hFFFFFFFE, 32'h00000001);

        // Start under flush is dropped.
        MDUOp = 4'd1;
        SrcA  = 32'd3;
        SrcB  = 32'd4;
        Start = 1'b1;
        Req   = 1'b1;
        tick();
        Start = 1'b0;
        Req   = 1'b0;
        MDUOp = 4'd0;
        chk("req start busy", {31'd0, Busy}, 32'd0);
        tick();
        chk("req start busy2", {31'd0, Busy}, 32'd0);
        chk("req start hi", HI, cur_hi);
        chk("req start lo", LO, cur_lo);

        // Req during a running mult does not abort it.
        MDUOp = 4'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        MDUOp = 4'd0;
        Req   = 1'b1;
        tick();
        Req = 1'b0;
        chk("req run busy", {31'd0, Busy}, 32'd1);
        tick();
        tick();
        tick();
        chk("req run busy4", {31'd0, Busy}, 32'd1);
        tick();
        chk("req run done", {31'd0, Busy}, 32'd0);
        chk("req run hi", HI, 32'd0);
        chk("req run lo", LO, 32'd12);
        cur_hi = 32'd0;
        cur_lo = 32'd12;

        // mthi while idle, then mfhi/mflo reads.
        MDUOp = 4'd5;
        SrcA  = 32'h12345678;
        #1;
        chk("mthi out", MDUOut, 32'd0);
        chk("mthi pre", HI, 32'd0);
        tick();
        chk("mthi hi", HI, 32'h12345678);
        cur_hi = 32'h12345678;
        MDUOp = 4'd8;
        #1;
        chk("mflo out", MDUOut, 32'd12);
        MDUOp = 4'd7;
        #1;
        chk("mfhi out", MDUOut, 32'h12345678);
        MDUOp = 4'd9;
        #1;
        chk("op9 out", MDUOut, 32'd0);

        // mtlo and a second Start while busy are both ignored.
        MDUOp = 4'd1;
        SrcA  = 32'd2;
        SrcB  = 32'd3;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        MDUOp = 4'd6;
        SrcA  = 32'hDEADBEEF;
        tick();
        chk("mtlo busy lo", LO, 32'd12);
        MDUOp = 4'd3;
        SrcA  = 32'd100;
        SrcB  = 32'd7;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        MDUOp = 4'd0;
        chk("dbl start busy", {31'd0, Busy}, 32'd1);
        tick();
        tick();
        chk("dbl start busy4", {31'd0, Busy}, 32'd1);
        tick();
        chk("dbl start done", {31'd0, Busy}, 32'd0);
        chk("dbl start hi", HI, 32'd0);
        chk("dbl start lo", LO, 32'd6);
        tick();
        chk("dbl no queue", {31'd0, Busy}, 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd6;

        // Divide by zero leaves HI/LO untouched.
        MDUOp = 4'd5;
        SrcA  = 32'hAA;
        tick();
        MDUOp = 4'd6;
        SrcA  = 32'hBB;
        tick();
        MDUOp = 4'd0;
        chk("mt hi", HI, 32'hAA);
        chk("mt lo", LO, 32'hBB);
        cur_hi = 32'hAA;
        cur_lo = 32'hBB;
        run_op("div0", 4'd3, 32'd5, 32'd0, 10, 32'hAA, 32'hBB);
        run_op("divu0", 4'd4, 32'd9, 32'd0, 10, 32'hAA, 32'hBB);
        run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10,
               32'd0, 32'h80000000);

        // Async reset in cycle 3 of a div discards the pending result.
        MDUOp = 4'd5;
        SrcA  = 32'h55;
        tick();
        MDUOp = 4'd3;
        SrcA  = 32'd1000;
        SrcB  = 32'd3;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        MDUOp = 4'd0;
        tick();
        tick();
        chk("pre rst busy", {31'd0, Busy}, 32'd1);
        chk("pre rst hi", HI, 32'h55);
        #2;
        reset = 1'b1;
        #1;
        chk("async busy", {31'd0, Busy}, 32'd0);
        chk("async hi", HI, 32'd0);
        chk("async lo", LO, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post rst busy", {31'd0, Busy}, 32'd0);
            chk("post rst hi", HI, 32'd0);
            chk("post rst lo", LO, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit of the P7 pipelined MIPS core. It sits beside the ALU and takes the same forwarded SrcA/SrcB operands. It runs mult/multu/div/divu over a fixed number of busy cycles and holds the architectural HI/LO registers. It also serves mthi/mtlo writes and mfhi/mflo reads, which the EX result mux selects in place of ALUResult. Busy/Start feed the hazard unit; Req from the exception/interrupt logic suppresses side effects of a flushed instruction.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  pulse: EX instruction is mult/multu/div/divu
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; other values act as none
- SrcA  input  32  rs operand, forwarded
- SrcB  input  32  rt operand, forwarded
- Req  input  1  exception/interrupt flush this cycle; EX instruction must not take effect
- Busy  output  1  operation in progress
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- MDUOut  output  32  combinational: HI if MDUOp=7, LO if MDUOp=8, else 0

## Operation
- State: IDLE / RUN. A 4-bit down-counter tracks RUN. Shadow registers hold the pending HI/LO result.
- Start is honoured only when Start=1, Req=0, Busy=0, and MDUOp is 1–4. Otherwise it is ignored.
- When Start is honoured, at that edge:
  - Compute the result into the shadow registers from the operands sampled that cycle.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Enter RUN.
- RUN: the counter decrements each edge. On the edge where it goes from 1 to 0, copy the shadow registers to HI/LO and return to IDLE.
- Operand arithmetic:
  - mult: signed 64-bit product, {HI,LO}.
  - multu: unsigned 64-bit product, {HI,LO}.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned quotient to LO, remainder to HI.
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Division by zero (div or divu): the unit still goes Busy for DIV_CYCLES. HI/LO stay unchanged at completion.
- mthi/mtlo write SrcA to HI/LO at the edge, only if Req=0 and Busy=0. Otherwise the write is dropped; the hazard unit stalls these while busy.
- Req does not abort an operation already in RUN. That operation belongs to an older, committed instruction and completes normally.
- HI/LO change only at completion, on mthi/mtlo, or on reset. Intermediate values are never visible.

## Timing
- Reset, async: Busy=0, HI=0, LO=0, counter=0, state IDLE. Outputs are valid while reset is held.
- Asserting reset mid-operation aborts the operation. The pending result is discarded and never written.
- Start sampled at edge E0 → Busy=1 from E0 through edge E0+N−1, where N=MULT_CYCLES or DIV_CYCLES.
- At edge E0+N: HI/LO are updated and Busy falls.
- New HI/LO are readable by mfhi in the cycle after that edge, giving N busy cycles.
- The hazard unit stalls any MDU-class instruction in D while Start|Busy. The block itself ignores illegal overlaps rather than queuing them.
- Start and Busy are never both honoured. If Start=1 while Busy=1, the running operation is unaffected.
- mthi/mtlo take effect at the edge of the cycle they are presented. MDUOut for mfhi/mflo reflects HI/LO as they are before that edge.
- Counter width must cover max(MULT_CYCLES, DIV_CYCLES) up to 15. A parameter value of 0 is illegal.

## Test plan
- Reset 0→1→0, then mult SrcA=0xFFFFFFFD, SrcB=5 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO read 0 during the busy window.
- divu 100/7 → Busy 10 cycles, then LO=14, HI=2. div 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. multu 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=1.
- Start with Req=1 (mult 3×4) → Busy stays 0, HI/LO unchanged. Then Req=1 arriving in cycle 2 of a running mult → the mult completes and writes normally.
- mthi 0x12345678 while idle → HI updates next edge; mflo shows LO combinationally. mtlo during Busy → ignored. A second Start during Busy → ignored; the first result is intact.
- div by zero with HI=0xAA, LO=0xBB → Busy 10 cycles, HI/LO still 0xAA/0xBB. Then div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Assert reset asynchronously mid-clock at cycle 3 of a div → Busy, HI, LO drop to 0 immediately. After release, no late write occurs.
